// File: rtl/ahb3lite_timer_pkg.sv
// Shared constants for the AHB3-Lite timer: register offsets, CTRL bit
// positions, AHB encodings and the slave FSM state type.
package ahb3lite_timer_pkg;

  // Word index (HADDR[4:2]) of each register.
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PRESC  = 3'd1;
  localparam logic [2:0] REG_CMP    = 3'd2;
  localparam logic [2:0] REG_CNT    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_ONESHOT = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  function automatic logic offset_mapped(input logic [2:0] idx);
    return idx <= REG_STATUS;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler plus compare/reload counter; owns CNT and the MATCH flag and
// tells the register file when a one-shot run has finished.
module timer_core #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               en,
  input  logic               oneshot,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   cmp,
  input  logic               start,
  input  logic               cnt_wr,
  input  logic [CNT_W-1:0]   cnt_wdata,
  input  logic               match_clr,
  output logic [CNT_W-1:0]   cnt,
  output logic               match,
  output logic               stop
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               match_q;
  logic               tick;
  logic               hit;

  assign tick  = en && (pcnt_q == presc);
  assign hit   = tick && (cnt_q == cmp);
  assign stop  = hit && oneshot;
  assign cnt   = cnt_q;
  assign match = match_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pcnt_q <= '0;
    end else if (!en || start || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESC_W'(1);
    end
  end

  // A bus write to CNT overrides the tick; a hardware match beats W1C.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      if (cnt_wr) begin
        cnt_q <= cnt_wdata;
      end else if (tick) begin
        cnt_q <= hit ? '0 : cnt_q + CNT_W'(1);
      end
      match_q <= hit | (match_q & ~match_clr);
    end
  end

endmodule

// File: rtl/ahb3lite_timer.sv
// AHB3-Lite slave wrapper: zero-wait-state register file with a two-cycle
// ERROR response for unmapped offsets or non-word transfers.
module ahb3lite_timer
  import ahb3lite_timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        irq
);

  ahb_state_e         state_q, state_d;
  logic [2:0]         addr_q;
  logic               write_q;
  logic [2:0]         ctrl_q;
  logic [PRESC_W-1:0] presc_q;
  logic [CNT_W-1:0]   cmp_q;
  logic [CNT_W-1:0]   cnt;
  logic               match;
  logic               core_stop;
  logic               accept, legal, wr_en;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign accept = HSEL && HTRANS[1] && HREADY;
  assign legal  = offset_mapped(HADDR[4:2]) && (HSIZE == HSIZE_WORD);
  assign wr_en  = (state_q == ST_DATA) && write_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: if (accept) state_d = legal ? ST_DATA : ST_ERR1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q != ST_ERR1) begin
        addr_q  <= HADDR[4:2];
        write_q <= HWRITE;
      end
    end
  end

  // A CTRL write takes priority over the one-shot auto-disable.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '1;
    end else begin
      if (wr_en && addr_q == REG_CTRL) begin
        ctrl_q <= HWDATA[2:0];
      end else if (core_stop) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end
      if (wr_en && addr_q == REG_PRESC) presc_q <= HWDATA[PRESC_W-1:0];
      if (wr_en && addr_q == REG_CMP)   cmp_q   <= HWDATA[CNT_W-1:0];
    end
  end

  timer_core #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_core (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .en        (ctrl_q[CTRL_EN]),
    .oneshot   (ctrl_q[CTRL_ONESHOT]),
    .presc     (presc_q),
    .cmp       (cmp_q),
    .start     (wr_en && addr_q == REG_CTRL && HWDATA[CTRL_EN]),
    .cnt_wr    (wr_en && addr_q == REG_CNT),
    .cnt_wdata (HWDATA[CNT_W-1:0]),
    .match_clr (wr_en && addr_q == REG_STATUS && HWDATA[0]),
    .cnt       (cnt),
    .match     (match),
    .stop      (core_stop)
  );

  always_comb begin
    rd_data = '0;
    case (addr_q)
      REG_CTRL:   rd_data[2:0]         = ctrl_q;
      REG_PRESC:  rd_data[PRESC_W-1:0] = presc_q;
      REG_CMP:    rd_data[CNT_W-1:0]   = cmp_q;
      REG_CNT:    rd_data[CNT_W-1:0]   = cnt;
      REG_STATUS: rd_data[0]           = match;
      default:    rd_data              = '0;
    endcase
  end

  assign HRDATA    = (state_q == ST_DATA) ? rd_data : '0;
  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign irq       = match && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_ahb3lite_timer.sv
// Directed bench for ahb3lite_timer: bus protocol, timer sequences, error
// responses, simultaneous events and asynchronous reset.
module tb_ahb3lite_timer;
  import ahb3lite_timer_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PRESC  = 32'h04;
  localparam logic [31:0] A_CMP    = 32'h08;
  localparam logic [31:0] A_CNT    = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        irq;

  logic [31:0] s_rdata;
  logic        s_ready, s_resp, s_irq;
  logic [31:0] rd;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  // Single-slave bus: the interconnect feeds HREADYOUT straight back.
  assign hready = hreadyout;

  ahb3lite_timer dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .irq       (irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: new address phase plus write data for the previous one;
  // outputs are sampled mid-cycle on the falling edge.
  task automatic step(input bit v, input logic [31:0] a, input bit w,
                      input logic [2:0] sz, input logic [31:0] wd);
    @(posedge Clk);
    #1;
    hsel   = v;
    htrans = v ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    hwdata = wd;
    @(negedge Clk);
    s_rdata = hrdata;
    s_ready = hreadyout;
    s_resp  = hresp;
    s_irq   = irq;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, 1'b1, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    step(1'b1, a, 1'b0, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    d = s_rdata;
  endtask

  task automatic do_reset();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    Rst_n  = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hreadyout"}, {31'b0, hreadyout}, 32'd1);
    check({tag, "_hresp"},     {31'b0, hresp},     32'd0);
    check({tag, "_hrdata"},    hrdata,             32'd0);
    check({tag, "_irq"},       {31'b0, irq},       32'd0);
  endtask

  task automatic check_reset_regs(input string tag);
    bus_read(A_CTRL, rd);   check({tag, "_ctrl"},   rd, 32'h0);
    bus_read(A_PRESC, rd);  check({tag, "_presc"},  rd, 32'h0);
    bus_read(A_CMP, rd);    check({tag, "_cmp"},    rd, 32'hFFFF_FFFF);
    bus_read(A_CNT, rd);    check({tag, "_cnt"},    rd, 32'h0);
    bus_read(A_STATUS, rd); check({tag, "_status"}, rd, 32'h0);
  endtask

  logic [31:0] exp_cnt [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

  initial begin
    // Power-on reset values.
    #2;
    check_reset_outputs("por");
    do_reset();
    check_reset_regs("por");

    // Back-to-back writes then consecutive CNT reads.
    do_reset();
    step(1'b1, A_PRESC, 1'b1, HSIZE_WORD, '0);
    step(1'b1, A_CMP,   1'b1, HSIZE_WORD, 32'd0);
    check("b2b_presc_ready", {31'b0, s_ready}, 32'd1);
    step(1'b1, A_CTRL,  1'b1, HSIZE_WORD, 32'd3);
    check("b2b_cmp_resp", {31'b0, s_resp}, 32'd0);
    step(1'b1, A_CNT,   1'b0, HSIZE_WORD, 32'd3);
    check("b2b_ctrl_ready", {31'b0, s_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, A_CNT, 1'b0, HSIZE_WORD, '0);
      check($sformatf("b2b_cnt%0d", i), s_rdata, (i == 4) ? 32'd0 : 32'(i));
      check($sformatf("b2b_resp%0d", i), {31'b0, s_resp}, 32'd0);
    end
    check("b2b_irq", {31'b0, s_irq}, 32'd1);
    bus_read(A_STATUS, rd);
    check("b2b_match", rd, 32'd1);

    // Unmapped read and halfword write: two-cycle ERROR, nothing changes.
    do_reset();
    step(1'b1, 32'h14, 1'b0, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("err_rd_c1_ready", {31'b0, s_ready}, 32'd0);
    check("err_rd_c1_resp",  {31'b0, s_resp},  32'd1);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("err_rd_c2_ready", {31'b0, s_ready}, 32'd1);
    check("err_rd_c2_resp",  {31'b0, s_resp},  32'd1);
    step(1'b1, A_CMP, 1'b1, HSIZE_HALF, '0);
    check("err_idle_resp", {31'b0, s_resp}, 32'd0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, 32'd5);
    check("err_hw_c1_ready", {31'b0, s_ready}, 32'd0);
    check("err_hw_c1_resp",  {31'b0, s_resp},  32'd1);
    step(1'b0, '0, 1'b0, HSIZE_WORD, 32'd5);
    check("err_hw_c2_resp", {31'b0, s_resp}, 32'd1);
    bus_read(A_CMP, rd);
    check("err_cmp_kept", rd, 32'hFFFF_FFFF);

    // One-shot: PRESC=2, CMP=1 -> tick every 3 cycles, stops after match.
    do_reset();
    bus_write(A_PRESC, 32'd2);
    bus_write(A_CMP, 32'd1);
    step(1'b1, A_CTRL, 1'b1, HSIZE_WORD, '0);
    step(1'b1, A_CNT, 1'b0, HSIZE_WORD, 32'd5);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, A_CNT, 1'b0, HSIZE_WORD, '0);
      check($sformatf("os_cnt%0d", i), s_rdata, exp_cnt[i]);
    end
    bus_read(A_CTRL, rd);
    check("os_ctrl_en_off", rd, 32'h4);
    bus_read(A_CNT, rd);
    check("os_cnt_held", rd, 32'd0);

    // W1C on the match cycle loses; IRQ_EN=0 keeps irq low.
    do_reset();
    bus_write(A_PRESC, 32'd0);
    bus_write(A_CMP, 32'd3);
    step(1'b1, A_CTRL, 1'b1, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, 32'd1);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    step(1'b1, A_STATUS, 1'b1, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, 32'd1);
    step(1'b1, A_STATUS, 1'b0, HSIZE_WORD, '0);
    check("w1c_irq_masked", {31'b0, s_irq}, 32'd0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("w1c_vs_set", s_rdata, 32'd1);
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, rd);
    check("w1c_clears", rd, 32'd0);

    // CNT write on a tick cycle wins over the increment.
    bus_write(A_CTRL, 32'd1);
    step(1'b1, A_CNT, 1'b1, HSIZE_WORD, '0);
    step(1'b1, A_CNT, 1'b0, HSIZE_WORD, 32'h10);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("cntwr_vs_tick", s_rdata, 32'h10);

    // Asynchronous reset during ERR1.
    do_reset();
    step(1'b1, 32'h18, 1'b0, HSIZE_WORD, '0);
    step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("arst_err1_ready", {31'b0, s_ready}, 32'd0);
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("arst_err1");
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    check_reset_regs("arst_err1");

    // Asynchronous reset while counting with irq asserted.
    bus_write(A_PRESC, 32'd0);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'd3);
    repeat (5) step(1'b0, '0, 1'b0, HSIZE_WORD, '0);
    check("arst_run_irq_before", {31'b0, s_irq}, 32'd1);
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("arst_run");
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    check_reset_regs("arst_run");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
